adc_dac: RTL and testbench

ADC_DAC -- requirements
Module: adc_dac

---
 rtl/adc_dac_if.sv | 37 +++
 rtl/adc_dac.sv | 63 ++++++
 tb/tb_adc_dac.sv | 121 ++++++++++++
 3 files changed

// File: rtl/adc_dac_if.sv
// Codec-side and user-side signal bundle for the adc_dac audio serialiser.
// The slave modport is the adc_dac view; the master modport is the user/codec-model view.
interface adc_dac_if;
    logic [31:0] dac_data_in;
    logic [31:0] adc_data_out;
    logic        m_clk;
    logic        b_clk;
    logic        dac_lr_clk;
    logic        adc_lr_clk;
    logic        dacdat;
    logic        adcdat;
    logic        load_done_tick;

    modport slave (
        input  dac_data_in,
        input  adcdat,
        output adc_data_out,
        output m_clk,
        output b_clk,
        output dac_lr_clk,
        output adc_lr_clk,
        output dacdat,
        output load_done_tick
    );

    modport master (
        output dac_data_in,
        output adcdat,
        input  adc_data_out,
        input  m_clk,
        input  b_clk,
        input  dac_lr_clk,
        input  adc_lr_clk,
        input  dacdat,
        input  load_done_tick
    );
endinterface

// File: rtl/adc_dac.sv
// Stereo audio codec serialiser: derives codec clocks from a 10-bit frame counter,
// shifts DAC samples out MSB first and collects ADC samples into a 32-bit word per frame.
module adc_dac (
    input  logic       clk,
    input  logic       reset,
    adc_dac_if.slave   bus
);
    logic [9:0]  q_reg;
    logic [31:0] dac_sr_reg;
    logic [31:0] adc_sr_reg;
    logic [31:0] adc_out_reg;

    logic frame_end;
    logic bit_end;
    logic bit_mid;

    assign frame_end = (q_reg == 10'd1023);
    assign bit_end   = (q_reg[4:0] == 5'd31);
    // Last clk before b_clk rises: the codec's data is settled mid-bit here.
    assign bit_mid   = (q_reg[4:0] == 5'd15);

    always_ff @(posedge clk) begin
        if (reset) begin
            q_reg <= 10'd0;
        end else begin
            q_reg <= q_reg + 10'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            dac_sr_reg <= 32'd0;
        end else if (frame_end) begin
            dac_sr_reg <= bus.dac_data_in;
        end else if (bit_end) begin
            dac_sr_reg <= {dac_sr_reg[30:0], 1'b0};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            adc_sr_reg <= 32'd0;
        end else if (bit_mid) begin
            adc_sr_reg <= {adc_sr_reg[30:0], bus.adcdat};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            adc_out_reg <= 32'd0;
        end else if (frame_end) begin
            adc_out_reg <= adc_sr_reg;
        end
    end

    assign bus.m_clk          = q_reg[1];
    assign bus.b_clk          = q_reg[4];
    assign bus.dac_lr_clk     = ~q_reg[9];
    assign bus.adc_lr_clk     = ~q_reg[9];
    assign bus.dacdat         = dac_sr_reg[31];
    assign bus.load_done_tick = frame_end;
    assign bus.adc_data_out   = adc_out_reg;
endmodule

// File: tb/tb_adc_dac.sv
// Directed bench for adc_dac: clock ratios, frame tick timing, DAC serial order,
// ADC capture, mid-frame input changes and mid-frame reset recovery.
module tb_adc_dac;
    logic clk;
    logic reset;
    int   passes;
    int   total;

    adc_dac_if bus ();

    adc_dac dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) passes++;
        else $error("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_mclk"}, {31'd0, bus.m_clk}, 32'd0);
        check({tag, "_bclk"}, {31'd0, bus.b_clk}, 32'd0);
        check({tag, "_lr"},   {30'd0, bus.dac_lr_clk, bus.adc_lr_clk}, 32'd3);
        check({tag, "_dacdat"}, {31'd0, bus.dacdat}, 32'd0);
        check({tag, "_tick"}, {31'd0, bus.load_done_tick}, 32'd0);
        check({tag, "_adcout"}, bus.adc_data_out, 32'd0);
    endtask

    // Runs one frame starting at the negedge where the counter is 0.
    // adc_mode: 0 = constant 0, 1 = constant 1, 2 = alternating 1,0,1.. per bit.
    task automatic run_frame(input string tag, input int adc_mode,
                             input logic [31:0] exp_ser, input logic [31:0] exp_prev,
                             input logic [31:0] exp_next, input bit clk_chk,
                             input bit change_dac, input logic [31:0] new_dac);
        logic [31:0] ser_a;
        logic [31:0] ser_b;
        int ticks;
        int tick_q;
        ser_a  = 32'd0;
        ser_b  = 32'd0;
        ticks  = 0;
        tick_q = -1;
        for (int q = 0; q < 1024; q++) begin
            if (q % 32 == 0) begin
                case (adc_mode)
                    0:       bus.adcdat = 1'b0;
                    1:       bus.adcdat = 1'b1;
                    default: bus.adcdat = ((q / 32) % 2 == 0);
                endcase
                ser_a[31 - q / 32] = bus.dacdat;
            end
            if (q % 32 == 31) ser_b[31 - q / 32] = bus.dacdat;
            if (bus.load_done_tick) begin
                ticks++;
                tick_q = q;
            end
            if (q == 500 && change_dac) bus.dac_data_in = new_dac;
            if (q == 700) check({tag, "_adc_hold"}, bus.adc_data_out, exp_prev);
            if (clk_chk) begin
                case (q)
                    1:    check("mclk_q1",  {31'd0, bus.m_clk}, 32'd0);
                    2:    check("mclk_q2",  {31'd0, bus.m_clk}, 32'd1);
                    4:    check("mclk_q4",  {31'd0, bus.m_clk}, 32'd0);
                    15:   check("bclk_q15", {31'd0, bus.b_clk}, 32'd0);
                    16:   check("bclk_q16", {31'd0, bus.b_clk}, 32'd1);
                    32:   check("bclk_q32", {31'd0, bus.b_clk}, 32'd0);
                    511:  check("lr_q511",  {30'd0, bus.dac_lr_clk, bus.adc_lr_clk}, 32'd3);
                    512:  check("lr_q512",  {30'd0, bus.dac_lr_clk, bus.adc_lr_clk}, 32'd0);
                    1023: check("lr_q1023", {30'd0, bus.dac_lr_clk, bus.adc_lr_clk}, 32'd0);
                    default: ;
                endcase
            end
            @(negedge clk);
        end
        check({tag, "_ser_start"}, ser_a, exp_ser);
        check({tag, "_ser_end"},   ser_b, exp_ser);
        check({tag, "_ticks"},     ticks, 32'd1);
        check({tag, "_tick_q"},    tick_q, 32'd1023);
        check({tag, "_tick_low"},  {31'd0, bus.load_done_tick}, 32'd0);
        check({tag, "_adc_next"},  bus.adc_data_out, exp_next);
        check({tag, "_lr_start"},  {31'd0, bus.dac_lr_clk}, 32'd1);
        $display("frame %s done: ser=%h adc_out=%h ticks=%0d", tag, ser_a, bus.adc_data_out, ticks);
    endtask

    initial begin
        passes = 0;
        total  = 0;
        reset  = 1'b1;
        bus.dac_data_in = 32'hAACCAACC;
        bus.adcdat      = 1'b0;
        repeat (4) @(negedge clk);
        check_reset_outputs("rst0");

        // Released here; the counter reads 0 at this negedge.
        reset = 1'b0;
        run_frame("f1", 2, 32'h00000000, 32'h00000000, 32'hAAAAAAAA, 1'b1, 1'b0, 32'd0);
        run_frame("f2", 0, 32'hAACCAACC, 32'hAAAAAAAA, 32'h00000000, 1'b0, 1'b1, 32'h12345678);
        run_frame("f3", 1, 32'h12345678, 32'h00000000, 32'hFFFFFFFF, 1'b0, 1'b0, 32'd0);

        // Partial frame with adcdat high, then a 100 ns reset at counter 600.
        bus.adcdat = 1'b1;
        repeat (600) @(negedge clk);
        check("pre_rst_adc", bus.adc_data_out, 32'hFFFFFFFF);
        check("pre_rst_lr",  {31'd0, bus.dac_lr_clk}, 32'd0);
        reset = 1'b1;
        repeat (5) @(negedge clk);
        check_reset_outputs("rst_mid");
        reset      = 1'b0;
        bus.adcdat = 1'b0;
        run_frame("f5", 0, 32'h00000000, 32'h00000000, 32'h00000000, 1'b1, 1'b0, 32'd0);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end
endmodule
